fetch_stage: RTL

Instruction fetch stage for the RV32I pipeline, directly upstream of decode. It owns the program counter and issues in-order word requests to instruction memory over a request/grant/response handshake. It buffers returned words with their PC in a small queue and presents them to decode over a valid/ready handshake. A redirect from execute flushes the queue, discards in-flight responses and restarts fetch at the new target.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 77 +++++++
 rtl/fetch_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode constants: widths, reset PC default, NOP encoding and the
// {pc, inst} queue entry layout.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] INST_NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    // Instruction fetches are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; head data comes straight from storage flops
// so the consumer sees a registered value.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [DEPTH-1:0] wr_en;
    logic             do_push;
    logic             do_pop;

    // Flush wins over any push or pop in the same cycle.
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign wr_en[gi] = do_push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_reg[i] <= push_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    assign count     = count_reg;
    assign head_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, issues in-order word requests, buffers
// responses with their PC and hands them to decode; redirects flush and restart.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            valid_ro,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_ro,
    output logic [ILEN-1:0] inst_ro
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    logic [CW-1:0]   kill_reg;
    logic [CW-1:0]   kill_next;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   q_count;
    logic [XLEN-1:0] pend_pc;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            grant;
    logic            pop;
    logic            q_push;
    logic [CW:0]     budget;

    assign pop = valid_ro & ready_i;

    // Reserve a queue slot for every in-flight request so responses never stall.
    assign budget     = {1'b0, outstanding} + {1'b0, q_count} - {{CW{1'b0}}, pop};
    assign imem_req_o = !rst && !redirect_i && (budget < (CW + 1)'(DEPTH));
    assign grant      = imem_req_o & imem_gnt_i;
    assign imem_addr_o = pc_reg;

    assign q_push     = imem_rvalid_i && (kill_reg == '0) && !redirect_i;
    assign push_entry = '{pc: pend_pc, inst: imem_rdata_i};

    always_comb begin
        pc_next   = pc_reg;
        kill_next = kill_reg;
        if (redirect_i) begin
            pc_next = align_word(redirect_pc_i);
            // Everything still due, minus a response landing right now, is stale.
            kill_next = outstanding - CW'(imem_rvalid_i);
        end else begin
            if (grant) begin
                pc_next = pc_reg + 32'd4;
            end
            if (imem_rvalid_i && (kill_reg != '0)) begin
                kill_next = kill_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg   <= RESET_PC;
            kill_reg <= '0;
        end else begin
            pc_reg   <= pc_next;
            kill_reg <= kill_next;
        end
    end

    // PCs of granted requests, in order; its occupancy is the outstanding count.
    fetch_queue #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pend_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (grant),
        .push_data (pc_reg),
        .pop       (imem_rvalid_i),
        .count     (outstanding),
        .head_data (pend_pc)
    );

    fetch_queue #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (pop),
        .count     (q_count),
        .head_data (head)
    );

    assign valid_ro = (q_count != '0);
    assign pc_ro    = head.pc;
    assign inst_ro  = head.inst;

endmodule
